// File: rtl/seg_scan_mux.sv
// Two-digit scan controller for a 7-segment display. It presents one hex nibble at a time,
// inserts blanked dead time between digits, and swaps in new values only at frame boundaries.
module seg_scan_mux #(
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       lz_en,
  output logic [3:0] digit,
  output logic       digit_sel,
  output logic       blank,
  output logic       frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SHOW  = REFRESH_DIV - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);

  // bit1 selects the high digit and bit0 marks a gap state, so outputs decode directly.
  typedef enum logic [1:0] {
    SHOW_LO = 2'd0,
    GAP_LO  = 2'd1,
    SHOW_HI = 2'd2,
    GAP_HI  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       pending, shadow;
  logic             lz_q;
  logic             last;
  logic             frame_end;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    last      = state[0] ? (cnt == GAP_LAST) : (cnt == SHOW_LAST);
    frame_end = (state == GAP_HI) && last;
    if (last) begin
      cnt_nxt = '0;
      case (state)
        SHOW_LO: state_nxt = GAP_LO;
        GAP_LO:  state_nxt = SHOW_HI;
        SHOW_HI: state_nxt = GAP_HI;
        default: state_nxt = SHOW_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GAP_HI;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pending <= '0;
    else if (load) pending <= value;
  end

  // The shadow samples pending as it stood before this edge, so a load that
  // coincides with the boundary shows up one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      lz_q   <= 1'b0;
    end else if (frame_end) begin
      shadow <= pending;
      lz_q   <= lz_en;
    end
  end

  always_comb begin
    digit_sel  = state[1];
    digit      = state[1] ? shadow[7:4] : shadow[3:0];
    blank      = state[0] | ((state == SHOW_HI) & lz_q & (shadow[7:4] == 4'h0));
    frame_tick = frame_end;
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux at REFRESH_DIV=8, BLANK_CYCLES=2: per-cycle expected outputs are
// queued from a scenario table and compared at the falling edge.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = '0;
  logic       load = 1'b0;
  logic       lz_en = 1'b0;
  logic [3:0] digit;
  logic       digit_sel, blank, frame_tick;

  int checks = 0;
  int failures = 0;

  seg_scan_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_en(lz_en),
    .digit(digit), .digit_sel(digit_sel), .blank(blank), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] digit;
    logic       sel;
    logic       blank;
    logic       tick;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } stim_t;

  typedef struct {
    string           name;
    logic            lz;
    int              ld_cyc0;
    logic [7:0]      ld_val0;
    int              ld_cyc1;
    logic [7:0]      ld_val1;
    int              nfr;
    logic [2:0][7:0] fv;   // value displayed in frame 0,1,2
  } scen_t;

  exp_t  sb[$];
  stim_t st[$];

  task automatic chk(input string nm, input int cyc, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d {digit,sel,blank,tick} got=%h_%b%b%b want=%h_%b%b%b",
               nm, cyc, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input int c, input logic [3:0] d, input logic s, input logic b, input logic t);
    exp_t e;
    e.cyc = c; e.digit = d; e.sel = s; e.blank = b; e.tick = t;
    sb.push_back(e);
  endtask

  // Frame f occupies cycles 16f+2 .. 16f+17 (show lo 6, gap lo 2, show hi 6, gap hi 2).
  task automatic push_frame(input int f, input logic [7:0] v, input logic lz);
    int b = 16 * f + 2;
    for (int k = 0; k < 16; k++) begin
      if (k < 6)       push(b + k, v[3:0], 1'b0, 1'b0, 1'b0);
      else if (k < 8)  push(b + k, v[3:0], 1'b0, 1'b1, 1'b0);
      else if (k < 14) push(b + k, v[7:4], 1'b1, lz && (v[7:4] == 4'h0), 1'b0);
      else             push(b + k, v[7:4], 1'b1, 1'b1, k == 15);
    end
  endtask

  task automatic do_reset(input logic lz);
    rst_n = 1'b0; load = 1'b0; value = '0; lz_en = lz;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;   // the remainder of this period is cycle 0
  endtask

  task automatic run(input string nm, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      load = 1'b0;
      if (st.size() > 0 && st[0].cyc == c) begin
        load  = 1'b1;
        value = st[0].val;
        void'(st.pop_front());
      end
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        exp_t e = sb.pop_front();
        chk(nm, c, {digit, digit_sel, blank, frame_tick}, {e.digit, e.sel, e.blank, e.tick});
      end
      @(posedge clk);
      #1;
    end
    load = 1'b0;
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      checks++; failures++;
      $display("FAIL %s expectation for cyc=%0d never reached", nm, e.cyc);
    end
    st.delete();
  endtask

  scen_t sc[6];

  initial begin
    // A load on the boundary cycle (cycle 1) misses the first frame.
    sc[0] = '{"boot_load",   1'b0,  1, 8'h3A, -1, 8'h00, 2, {8'h00, 8'h3A, 8'h00}};
    sc[1] = '{"free_run",    1'b0, -1, 8'h00, -1, 8'h00, 3, {8'h00, 8'h00, 8'h00}};
    sc[2] = '{"last_wins",   1'b0,  3, 8'h12,  9, 8'h34, 2, {8'h00, 8'h34, 8'h00}};
    sc[3] = '{"load_bound",  1'b0,  5, 8'h21, 17, 8'h55, 3, {8'h55, 8'h21, 8'h00}};
    sc[4] = '{"lz_on",       1'b1,  3, 8'h07, -1, 8'h00, 2, {8'h00, 8'h07, 8'h00}};
    sc[5] = '{"lz_off",      1'b0,  3, 8'h07, -1, 8'h00, 2, {8'h00, 8'h07, 8'h00}};

    for (int i = 0; i < 6; i++) begin
      stim_t s;
      do_reset(sc[i].lz);
      push(0, 4'h0, 1'b1, 1'b1, 1'b0);
      push(1, 4'h0, 1'b1, 1'b1, 1'b1);
      for (int f = 0; f < sc[i].nfr; f++) push_frame(f, sc[i].fv[f], sc[i].lz);
      if (sc[i].ld_cyc0 >= 0) begin s.cyc = sc[i].ld_cyc0; s.val = sc[i].ld_val0; st.push_back(s); end
      if (sc[i].ld_cyc1 >= 0) begin s.cyc = sc[i].ld_cyc1; s.val = sc[i].ld_val1; st.push_back(s); end
      run(sc[i].name, 16 * sc[i].nfr + 2);
    end

    // Mid-frame reset: 0x9C loaded in cycle 0 is on display, high digit 9 at cycle 12.
    begin
      stim_t s;
      do_reset(1'b0);
      s.cyc = 0; s.val = 8'h9C; st.push_back(s);
      push(11, 4'h9, 1'b1, 1'b0, 1'b0);
      run("pre_reset", 12);
      #2;
      chk("mid_show_hi", 12, {digit, digit_sel, blank, frame_tick}, {4'h9, 1'b1, 1'b0, 1'b0});
      rst_n = 1'b0;
      #1;
      chk("async_reset", 12, {digit, digit_sel, blank, frame_tick}, {4'h0, 1'b1, 1'b1, 1'b0});
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(0, 4'h0, 1'b1, 1'b1, 1'b0);
      push(1, 4'h0, 1'b1, 1'b1, 1'b1);
      push_frame(0, 8'h00, 1'b0);   // pending was cleared, so nothing of 0x9C survives
      run("post_reset", 18);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
